// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned 32x32 multiply (shift-add) and divide (restoring)
// sequencer. All per-iteration arithmetic goes through an external 32-bit adder on the
// add_* ports. The sequencer holds HI/LO for MFHI/MFLO.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  input  logic        add_c
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        opr_q, opr_d;
  logic [31:0] d_q, d_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Divide: remainder shifted left by one, pulling in the next dividend bit.
  logic [31:0] rem;
  // Divide: quotient bit. hi_q[31] covers the 33rd remainder bit lost by the shift.
  logic        q_bit;

  assign rem   = {hi_q[30:0], lo_q[31]};
  assign q_bit = hi_q[31] | add_c;

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Drive the shared adder only while iterating; idle at zero otherwise.
  always_comb begin
    add_a   = 32'd0;
    add_b   = 32'd0;
    add_cin = 1'b0;
    if (state_q == StRun) begin
      if (opr_q) begin
        // Trial subtract: rem - d as rem + ~d + 1.
        add_a   = rem;
        add_b   = ~d_q;
        add_cin = 1'b1;
      end else begin
        add_a   = hi_q;
        add_b   = lo_q[0] ? d_q : 32'd0;
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opr_d   = opr_q;
    d_d     = d_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          hi_d    = 32'd0;
          lo_d    = srca;
          d_d     = srcb;
          opr_d   = op;
          cnt_d   = 5'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 5'd1;
        if (opr_q) begin
          hi_d = q_bit ? add_sum : rem;
          lo_d = {lo_q[30:0], q_bit};
        end else begin
          // Carry-out becomes the new top bit; the consumed multiplier bit shifts out.
          {hi_d, lo_d} = {add_c, add_sum, lo_q[31:1]};
        end
        if (cnt_q == 5'd31) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      opr_q   <= 1'b0;
      d_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opr_q   <= opr_d;
      d_q     <= d_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq. The bench supplies the external ripple adder.
module tb_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_c;
  logic [32:0] sum33;

  int nvec = 0;
  int nerr = 0;

  // External adder that the parent would normally provide.
  assign sum33   = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
  assign add_sum = sum33[31:0];
  assign add_c   = sum33[32];

  muldiv_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .srca    (srca),
    .srcb    (srcb),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_cin (add_cin),
    .add_sum (add_sum),
    .add_c   (add_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and observe 40 cycles after the start edge.
  // p1/p2: cycle indices during which a stray start (DIVU, junk operands) is raised.
  // rc: cycle index during which reset is raised (0 = none); checks the cycle after.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input int p1, input int p2, input int rc,
                        output int dcyc, output int bcnt, output int nd,
                        output logic [31:0] rhi, output logic [31:0] rlo,
                        output logic [31:0] fa, output logic [31:0] fb, output logic fc);
    dcyc = 0; bcnt = 0; nd = 0; rhi = 32'hdeadbeef; rlo = 32'hdeadbeef;
    fa = 32'd0; fb = 32'd0; fc = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = o; srca = a; srcb = b;
    @(posedge clk); #1;  // E0 has just happened
    start = 1'b0;
    for (int idx = 1; idx <= 40; idx++) begin
      if (idx == p1 || idx == p2) begin
        start = 1'b1; op = 1'b1; srca = 32'h0badf00d; srcb = 32'h00000003;
      end
      if (rc != 0 && idx == rc) reset = 1'b1;
      if (idx == 1) begin
        fa = add_a; fb = add_b; fc = add_cin;
      end
      if (busy) bcnt++;
      if (done) begin
        nd++; dcyc = idx; rhi = hi; rlo = lo;
      end
      if (rc != 0 && idx == rc + 1) begin
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
          nerr++;
          $display("FAIL abort_state: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0",
                   busy, done, hi, lo);
        end
      end
      @(posedge clk); #1;
      start = 1'b0; reset = 1'b0; op = o;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++; $display("FAIL reset_ctrl: busy=%b done=%b, want 0 0", busy, done);
    end
    nvec++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      nerr++; $display("FAIL reset_hilo: hi=%h lo=%h, want 0 0", hi, lo);
    end
    nvec++;
    if (add_a !== 32'd0 || add_b !== 32'd0 || add_cin !== 1'b0) begin
      nerr++;
      $display("FAIL reset_adder: a=%h b=%h cin=%b, want 0 0 0", add_a, add_b, add_cin);
    end
    // Reset wins over a simultaneous start.
    start = 1'b1; op = 1'b0; srca = 32'd9; srcb = 32'd9;
    @(posedge clk); #1;
    nvec++;
    if (busy !== 1'b0 || lo !== 32'd0) begin
      nerr++; $display("FAIL reset_vs_start: busy=%b lo=%h, want 0 0", busy, lo);
    end
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    int dc, bc, nd; logic [31:0] rh, rl, fa, fb; logic fc;
    run_op(1'b0, 32'd7, 32'd6, 0, 0, 0, dc, bc, nd, rh, rl, fa, fb, fc);
    nvec++;
    if (nd !== 1 || dc !== 33) begin
      nerr++; $display("FAIL mul_done_timing: pulses=%0d cycle=%0d, want 1 at 33", nd, dc);
    end
    // RUN for 32 cycles plus DONE for 1.
    nvec++;
    if (bc !== 33) begin
      nerr++; $display("FAIL mul_busy_len: got %0d, want 33", bc);
    end
    nvec++;
    if (rh !== 32'd0 || rl !== 32'h0000002a) begin
      nerr++; $display("FAIL mul_7x6: hi=%h lo=%h, want 00000000 0000002a", rh, rl);
    end
    nvec++;
    if (fa !== 32'd0 || fb !== 32'd6 || fc !== 1'b0) begin
      nerr++; $display("FAIL mul_adder_drive: a=%h b=%h cin=%b, want 0 6 0", fa, fb, fc);
    end
    nvec++;
    if (hi !== 32'd0 || lo !== 32'h0000002a || busy !== 1'b0) begin
      nerr++; $display("FAIL mul_hold: hi=%h lo=%h busy=%b, want 0 2a 0", hi, lo, busy);
    end
    run_op(1'b0, 32'hffffffff, 32'hffffffff, 0, 0, 0, dc, bc, nd, rh, rl, fa, fb, fc);
    nvec++;
    if (nd !== 1 || rh !== 32'hfffffffe || rl !== 32'h00000001) begin
      nerr++;
      $display("FAIL mul_max: pulses=%0d hi=%h lo=%h, want 1 fffffffe 00000001", nd, rh, rl);
    end
  endtask

  task automatic test_divu();
    int dc, bc, nd; logic [31:0] rh, rl, fa, fb; logic fc;
    run_op(1'b1, 32'd100, 32'd7, 0, 0, 0, dc, bc, nd, rh, rl, fa, fb, fc);
    nvec++;
    if (nd !== 1 || dc !== 33 || rl !== 32'd14 || rh !== 32'd2) begin
      nerr++;
      $display("FAIL div_100_7: pulses=%0d cyc=%0d q=%0d r=%0d, want 1 33 14 2", nd, dc, rl, rh);
    end
    nvec++;
    if (fa !== 32'd0 || fb !== 32'hfffffff8 || fc !== 1'b1) begin
      nerr++;
      $display("FAIL div_adder_drive: a=%h b=%h cin=%b, want 0 fffffff8 1", fa, fb, fc);
    end
    run_op(1'b1, 32'hffffffff, 32'd1, 0, 0, 0, dc, bc, nd, rh, rl, fa, fb, fc);
    nvec++;
    if (nd !== 1 || rl !== 32'hffffffff || rh !== 32'd0) begin
      nerr++; $display("FAIL div_max_1: q=%h r=%h, want ffffffff 00000000", rl, rh);
    end
  endtask

  task automatic test_div_zero();
    int dc, bc, nd; logic [31:0] rh, rl, fa, fb; logic fc;
    run_op(1'b1, 32'h12345678, 32'd0, 0, 0, 0, dc, bc, nd, rh, rl, fa, fb, fc);
    nvec++;
    if (nd !== 1 || dc !== 33) begin
      nerr++; $display("FAIL div0_timing: pulses=%0d cycle=%0d, want 1 at 33", nd, dc);
    end
    nvec++;
    if (rl !== 32'hffffffff || rh !== 32'h12345678) begin
      nerr++; $display("FAIL div0_result: lo=%h hi=%h, want ffffffff 12345678", rl, rh);
    end
  endtask

  task automatic test_start_while_busy();
    int dc, bc, nd; logic [31:0] rh, rl, fa, fb; logic fc;
    run_op(1'b0, 32'd3, 32'd5, 10, 32, 0, dc, bc, nd, rh, rl, fa, fb, fc);
    nvec++;
    if (nd !== 1 || dc !== 33) begin
      nerr++; $display("FAIL busy_start_pulses: pulses=%0d cycle=%0d, want 1 at 33", nd, dc);
    end
    nvec++;
    if (rh !== 32'd0 || rl !== 32'd15) begin
      nerr++; $display("FAIL busy_start_result: hi=%h lo=%h, want 0 0000000f", rh, rl);
    end
    nvec++;
    if (bc !== 33) begin
      nerr++; $display("FAIL busy_start_len: got %0d, want 33", bc);
    end
  endtask

  task automatic test_reset_abort();
    int dc, bc, nd; logic [31:0] rh, rl, fa, fb; logic fc;
    run_op(1'b1, 32'd100, 32'd7, 0, 0, 12, dc, bc, nd, rh, rl, fa, fb, fc);
    nvec++;
    if (nd !== 0) begin
      nerr++; $display("FAIL abort_no_done: got %0d pulses, want 0", nd);
    end
    run_op(1'b0, 32'd2, 32'd3, 0, 0, 0, dc, bc, nd, rh, rl, fa, fb, fc);
    nvec++;
    if (nd !== 1 || dc !== 33 || rh !== 32'd0 || rl !== 32'd6) begin
      nerr++;
      $display("FAIL after_abort_2x3: pulses=%0d cyc=%0d hi=%h lo=%h, want 1 33 0 6",
               nd, dc, rh, rl);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 1'b0; srca = 32'd0; srcb = 32'd0;
    test_reset();
    test_multu();
    test_divu();
    test_div_zero();
    test_start_while_busy();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
